window_sum_ctrl: RTL and testbench
==================================

WINDOW_SUM_CTRL -- requirements
Module: window_sum_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, window length in samples; power of two, at least 2.
REQ-003 SHALL have port clk  in  1  clock; all logic on the rising edge.
REQ-004 SHALL have port srst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  in  1  one-cycle pulse requesting that the window be emptied.
REQ-006 SHALL have ports s_valid  in  1, s_ready  out  1 and s_data  in  WIDTH, forming the input sample handshake.
REQ-007 SHALL have ports fifo_wr_en  out  1 and fifo_din  out  WIDTH, forming the write side of the external window FIFO.
REQ-008 SHALL have ports fifo_rd_en  out  1, fifo_dout  in  WIDTH, fifo_valid  in  1 and fifo_empty  in  1; fifo_dout is valid the cycle after fifo_rd_en, flagged by fifo_valid.
REQ-009 SHALL have port total  out  WIDTH+$clog2(DEPTH)  sum of samples currently in the window.
REQ-010 SHALL have ports total_valid  out  1, window_full  out  1 (window holds DEPTH samples) and busy  out  1 (high in CLEAR).
REQ-011 SHALL have port err  out  1  sticky protocol error.

Function
REQ-012 SHALL implement the FSM states CLEAR, FILL, SLIDE_RD and SLIDE_WR.
REQ-013 In CLEAR: s_ready=0; fifo_rd_en=1 while !fifo_empty; returned data discarded; total held at 0; move to FILL the first cycle fifo_empty=1 and no read is outstanding.
REQ-014 In FILL: s_ready=1; a transfer (s_valid&&s_ready) drives fifo_wr_en=1 and fifo_din=s_data that cycle, adds s_data to total and increments count; when count reaches DEPTH, move to SLIDE_RD.
REQ-015 In SLIDE_RD: s_ready=1; a transfer captures s_data into a hold register, asserts fifo_rd_en=1 and moves to SLIDE_WR; no write is issued this cycle, so the FIFO is never written while full.
REQ-016 In SLIDE_WR: s_ready=0; if fifo_valid, drive fifo_wr_en=1 with fifo_din=hold, set total <= total + hold - fifo_dout and return to SLIDE_RD; else remain.
REQ-017 SLIDE throughput SHALL be one sample per 2 cycles; FILL throughput SHALL be one sample per cycle.
REQ-018 total_valid SHALL be 1 in FILL and SLIDE_RD and 0 in CLEAR and SLIDE_WR; total SHALL update the cycle after the accepting edge.
REQ-019 window_full SHALL be 1 exactly in SLIDE_RD and SLIDE_WR.
REQ-020 Arithmetic SHALL be unsigned; subtraction is performed at full total width; no saturation is needed because total never exceeds DEPTH*(2^WIDTH-1).
REQ-021 flush in any state SHALL move to CLEAR the next cycle and zero total and count; an in-flight read's data is discarded; a held sample in SLIDE_WR is dropped.
REQ-022 flush coincident with s_valid SHALL win: s_ready=0 that cycle.
REQ-023 fifo_valid while no read is outstanding, or fifo_empty=1 in SLIDE_RD/SLIDE_WR, SHALL set err=1; err clears only on srst.

Reset
REQ-024 srst SHALL dominate flush and all other inputs.
REQ-025 On srst, the FSM SHALL enter CLEAR and total=0, count=0, hold=0, err=0, s_ready=0, fifo_wr_en=0 and total_valid=0 take effect the next cycle.
REQ-026 After srst the block SHALL drain any residual FIFO content before accepting samples, so srst need last only 1 cycle.

Configuration
REQ-027 Macro WINDOW_SUM_CTRL_AVG_EN SHALL be the only compile option.
REQ-028 With WINDOW_SUM_CTRL_AVG_EN defined, the block SHALL add output avg  out  WIDTH = total >> $clog2(DEPTH), registered, and valid alongside total_valid && window_full.
REQ-029 Without WINDOW_SUM_CTRL_AVG_EN, the avg port and its logic SHALL be absent.

Verification
REQ-030 srst with 5 residual FIFO entries -> exactly 5 fifo_rd_en pulses, busy=1 throughout, then FILL with total=0 and s_ready=1.
REQ-031 WIDTH=8, DEPTH=4, samples 1,2,3,4 on back-to-back cycles -> total 1,3,6,10; window_full=1 after the 4th sample.
REQ-032 Then samples 10 and 255 -> total 19 (drops 1), then 272 (drops 2); total_valid=0 in each SLIDE_WR cycle; s_ready alternates 1/0.
REQ-033 Window of 4x255 -> total=1020 with no overflow; avg=255 when WINDOW_SUM_CTRL_AVG_EN is defined.
REQ-034 flush in SLIDE_WR while fifo_valid is high -> no write issued, CLEAR drains the remaining 3 entries, total=0.
REQ-035 Spurious fifo_valid in FILL -> err=1 and stays 1 until srst.

Source files
------------

// File: rtl/window_sum_ctrl.sv
// window_sum_ctrl: sliding-window sum kept in an external FIFO. Build option
// WINDOW_SUM_CTRL_AVG_EN adds a registered avg output (total / DEPTH).
module window_sum_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             srst,
    input  logic                             flush,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [WIDTH-1:0]                 s_data,
    output logic                             fifo_wr_en,
    output logic [WIDTH-1:0]                 fifo_din,
    output logic                             fifo_rd_en,
    input  logic [WIDTH-1:0]                 fifo_dout,
    input  logic                             fifo_valid,
    input  logic                             fifo_empty,
    output logic [WIDTH+$clog2(DEPTH)-1:0]   total,
    output logic                             total_valid,
    output logic                             window_full,
    output logic                             busy,
    output logic                             err
`ifdef WINDOW_SUM_CTRL_AVG_EN
    ,
    output logic [WIDTH-1:0]                 avg
`endif
);
    localparam int LG = $clog2(DEPTH);
    localparam int TW = WIDTH + LG;

    typedef enum logic [1:0] {CLEAR, FILL, SLIDE_RD, SLIDE_WR} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   total_q, total_d;
    logic [LG:0]     count_q, count_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic            err_q, err_d;
    logic            rd_pend_q, rd_pend_d;
    logic            xfer;

    assign total       = total_q;
    assign total_valid = (state_q == FILL) || (state_q == SLIDE_RD);
    assign window_full = (state_q == SLIDE_RD) || (state_q == SLIDE_WR);
    assign busy        = (state_q == CLEAR);
    assign err         = err_q;

    // Next-state, handshake and FIFO control; srst overrides flush, flush overrides everything else
    always_comb begin
        state_d    = state_q;
        total_d    = total_q;
        count_d    = count_q;
        hold_d     = hold_q;
        s_ready    = !srst && !flush && ((state_q == FILL) || (state_q == SLIDE_RD));
        xfer       = s_valid && s_ready;
        fifo_wr_en = 1'b0;
        fifo_din   = s_data;
        fifo_rd_en = 1'b0;
        case (state_q)
            CLEAR: begin
                fifo_rd_en = !srst && !flush && !fifo_empty;
                if (fifo_empty && !rd_pend_q) state_d = FILL;
            end
            FILL: if (xfer) begin
                fifo_wr_en = 1'b1;
                total_d    = total_q + TW'(s_data);
                count_d    = count_q + (LG+1)'(1);
                if (count_q == (LG+1)'(DEPTH-1)) state_d = SLIDE_RD;
            end
            SLIDE_RD: if (xfer) begin
                hold_d     = s_data;
                fifo_rd_en = 1'b1;
                state_d    = SLIDE_WR;
            end
            SLIDE_WR: if (fifo_valid) begin
                fifo_wr_en = !srst && !flush;
                fifo_din   = hold_q;
                total_d    = total_q + TW'(hold_q) - TW'(fifo_dout);
                state_d    = SLIDE_RD;
            end
        endcase
        rd_pend_d = fifo_rd_en;
        err_d     = err_q || (fifo_valid && !rd_pend_q) || (fifo_empty && window_full);
        if (flush) begin
            state_d = CLEAR;
            total_d = '0;
            count_d = '0;
        end
        if (srst) begin
            state_d   = CLEAR;
            total_d   = '0;
            count_d   = '0;
            hold_d    = '0;
            err_d     = 1'b0;
            rd_pend_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        state_q   <= state_d;
        total_q   <= total_d;
        count_q   <= count_d;
        hold_q    <= hold_d;
        err_q     <= err_d;
        rd_pend_q <= rd_pend_d;
    end

`ifdef WINDOW_SUM_CTRL_AVG_EN
    // Average registered alongside total so both change on the same edge
    always_ff @(posedge clk) begin
        avg <= total_d[TW-1:LG];
    end
`endif
endmodule

// File: tb/tb_window_sum_ctrl.sv
// tb_window_sum_ctrl: directed bench for window_sum_ctrl (WIDTH=8, DEPTH=4) with a 1-cycle-latency FIFO model
module tb_window_sum_ctrl;
    localparam int TW = 10;

    logic          clk = 1'b0, srst = 1'b1, flush = 1'b0, s_valid = 1'b0;
    logic [7:0]    s_data = '0;
    logic          s_ready, fifo_wr_en, fifo_rd_en, fifo_valid, fifo_empty;
    logic [7:0]    fifo_din, fifo_dout;
    logic [TW-1:0] total;
    logic          total_valid, window_full, busy, err;
`ifdef WINDOW_SUM_CTRL_AVG_EN
    logic [7:0]    avg;
`endif
    int ntot = 0, nbad = 0;

    logic [7:0] mem [16];
    logic [3:0] wp = '0, rp = '0;
    logic       fv = 1'b0, inj = 1'b0, tb_wr = 1'b0;
    logic [7:0] tb_din = '0, fdout = '0;

    assign fifo_valid = fv | inj;
    assign fifo_empty = (wp == rp);
    assign fifo_dout  = fdout;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fdout <= mem[rp];
            rp    <= rp + 4'd1;
            fv    <= 1'b1;
        end else begin
            fv <= 1'b0;
        end
        if (fifo_wr_en || tb_wr) begin
            mem[wp] <= fifo_wr_en ? fifo_din : tb_din;
            wp      <= wp + 4'd1;
        end
    end

    window_sum_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .srst(srst), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .fifo_valid(fifo_valid), .fifo_empty(fifo_empty),
        .total(total), .total_valid(total_valid), .window_full(window_full),
        .busy(busy), .err(err)
`ifdef WINDOW_SUM_CTRL_AVG_EN
        , .avg(avg)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int n = 0;
        for (int i = 0; i < 5; i++) begin
            tb_wr = 1'b1; tb_din = 8'(50 + i);
            tick();
        end
        tb_wr = 1'b0;
        tick();
        srst = 1'b0;
        #1;
        ntot++; if (busy !== 1'b1) begin nbad++; $display("FAIL rst_busy: got %b want 1", busy); end
        ntot++; if (s_ready !== 1'b0) begin nbad++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
        ntot++; if (total !== 10'd0) begin nbad++; $display("FAIL rst_total: got %0d want 0", total); end
        ntot++; if (total_valid !== 1'b0) begin nbad++; $display("FAIL rst_total_valid: got %b want 0", total_valid); end
        ntot++; if (err !== 1'b0) begin nbad++; $display("FAIL rst_err: got %b want 0", err); end
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            if (fifo_rd_en) n++;
            tick();
        end
        ntot++; if (busy !== 1'b0) begin nbad++; $display("FAIL rst_drain_done: busy got %b want 0", busy); end
        ntot++; if (n != 5) begin nbad++; $display("FAIL rst_rd_pulses: got %0d want 5", n); end
        ntot++; if (s_ready !== 1'b1) begin nbad++; $display("FAIL rst_fill_ready: got %b want 1", s_ready); end
        ntot++; if (total !== 10'd0) begin nbad++; $display("FAIL rst_fill_total: got %0d want 0", total); end
        ntot++; if (err !== 1'b0) begin nbad++; $display("FAIL rst_drain_err: got %b want 0", err); end
    endtask

    task automatic test_fill;
        logic [7:0] v [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
        int e [4] = '{1, 3, 6, 10};
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = v[i];
            #1;
            ntot++; if (s_ready !== 1'b1) begin nbad++; $display("FAIL fill_ready[%0d]: got %b want 1", i, s_ready); end
            ntot++; if (fifo_wr_en !== 1'b1 || fifo_din !== v[i]) begin nbad++; $display("FAIL fill_wr[%0d]: got en=%b din=%0d want en=1 din=%0d", i, fifo_wr_en, fifo_din, v[i]); end
            tick();
            ntot++; if (total !== TW'(e[i])) begin nbad++; $display("FAIL fill_total[%0d]: got %0d want %0d", i, total, e[i]); end
            ntot++; if (window_full !== (i == 3)) begin nbad++; $display("FAIL fill_full[%0d]: got %b want %b", i, window_full, i == 3); end
        end
        s_valid = 1'b0;
        #1;
        ntot++; if (total_valid !== 1'b1) begin nbad++; $display("FAIL fill_total_valid: got %b want 1", total_valid); end
    endtask

    task automatic test_slide;
        logic [7:0] v [2] = '{8'd10, 8'd255};
        int e [2] = '{19, 272};
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_data = v[i];
            #1;
            ntot++; if (s_ready !== 1'b1 || fifo_rd_en !== 1'b1 || fifo_wr_en !== 1'b0) begin nbad++; $display("FAIL slide_rd[%0d]: got ready=%b rd=%b wr=%b want 1 1 0", i, s_ready, fifo_rd_en, fifo_wr_en); end
            tick();
            s_data = 8'hEE;
            #1;
            ntot++; if (s_ready !== 1'b0 || total_valid !== 1'b0) begin nbad++; $display("FAIL slide_wr_flags[%0d]: got ready=%b tv=%b want 0 0", i, s_ready, total_valid); end
            ntot++; if (fifo_wr_en !== 1'b1 || fifo_din !== v[i]) begin nbad++; $display("FAIL slide_wr[%0d]: got en=%b din=%0d want en=1 din=%0d", i, fifo_wr_en, fifo_din, v[i]); end
            tick();
            ntot++; if (total !== TW'(e[i]) || total_valid !== 1'b1) begin nbad++; $display("FAIL slide_total[%0d]: got %0d tv=%b want %0d tv=1", i, total, total_valid, e[i]); end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_full_scale;
        int e [4] = '{524, 775, 1020, 1020};
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 8'd255;
            tick();
            s_valid = 1'b0;
            tick();
            ntot++; if (total !== TW'(e[i])) begin nbad++; $display("FAIL max_total[%0d]: got %0d want %0d", i, total, e[i]); end
        end
        ntot++; if (window_full !== 1'b1 || err !== 1'b0) begin nbad++; $display("FAIL max_flags: got full=%b err=%b want 1 0", window_full, err); end
`ifdef WINDOW_SUM_CTRL_AVG_EN
        ntot++; if (avg !== 8'd255) begin nbad++; $display("FAIL max_avg: got %0d want 255", avg); end
`endif
    endtask

    task automatic test_flush;
        int n = 0;
        s_valid = 1'b1; s_data = 8'd7;
        tick();
        s_valid = 1'b0; flush = 1'b1;
        #1;
        ntot++; if (fifo_valid !== 1'b1 || fifo_wr_en !== 1'b0 || s_ready !== 1'b0) begin nbad++; $display("FAIL flush_wr: got valid=%b wr=%b ready=%b want 1 0 0", fifo_valid, fifo_wr_en, s_ready); end
        tick();
        flush = 1'b0;
        #1;
        ntot++; if (busy !== 1'b1 || total !== 10'd0 || window_full !== 1'b0) begin nbad++; $display("FAIL flush_clear: got busy=%b total=%0d full=%b want 1 0 0", busy, total, window_full); end
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            if (fifo_rd_en) n++;
            tick();
        end
        ntot++; if (busy !== 1'b0) begin nbad++; $display("FAIL flush_drain_done: busy got %b want 0", busy); end
        ntot++; if (n != 3) begin nbad++; $display("FAIL flush_rd_pulses: got %0d want 3", n); end
        ntot++; if (total !== 10'd0 || s_ready !== 1'b1 || err !== 1'b0) begin nbad++; $display("FAIL flush_fill: got total=%0d ready=%b err=%b want 0 1 0", total, s_ready, err); end
        s_valid = 1'b1; s_data = 8'd9; flush = 1'b1;
        #1;
        ntot++; if (s_ready !== 1'b0 || fifo_wr_en !== 1'b0) begin nbad++; $display("FAIL flush_wins: got ready=%b wr=%b want 0 0", s_ready, fifo_wr_en); end
        tick();
        flush = 1'b0; s_valid = 1'b0;
        ntot++; if (busy !== 1'b1) begin nbad++; $display("FAIL flush_wins_clear: busy got %b want 1", busy); end
        tick();
        ntot++; if (busy !== 1'b0 || total !== 10'd0 || fifo_empty !== 1'b1) begin nbad++; $display("FAIL flush_wins_fill: got busy=%b total=%0d empty=%b want 0 0 1", busy, total, fifo_empty); end
    endtask

    task automatic test_err;
        ntot++; if (err !== 1'b0) begin nbad++; $display("FAIL err_pre: got %b want 0", err); end
        inj = 1'b1;
        tick();
        inj = 1'b0;
        ntot++; if (err !== 1'b1) begin nbad++; $display("FAIL err_set: got %b want 1", err); end
        for (int i = 0; i < 3; i++) tick();
        ntot++; if (err !== 1'b1) begin nbad++; $display("FAIL err_sticky: got %b want 1", err); end
        srst = 1'b1;
        tick();
        srst = 1'b0;
        ntot++; if (err !== 1'b0 || busy !== 1'b1) begin nbad++; $display("FAIL err_srst: got err=%b busy=%b want 0 1", err, busy); end
        tick();
        tick();
        ntot++; if (err !== 1'b0 || busy !== 1'b0) begin nbad++; $display("FAIL err_after: got err=%b busy=%b want 0 0", err, busy); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_slide();
        test_full_scale();
        test_flush();
        test_err();
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end
endmodule
